memarbiter: RTL and testbench

Single-port memory arbiter for the pipelined ARM core. It shares one unified instruction/data memory between the fetch stage and the memory stage. It grants one access at a time and counts memory wait states. It returns registered read data to the winning requester and drives `stallf`/`stallm` back to the hazard logic. It sits between the fetch stage (`pcf`), the MEM-stage load/store path, and the memory macro.

---
 rtl/memarb_pkg.sv | 13 +
 rtl/memarb_fetchbuf.sv | 40 ++++
 rtl/memarbiter.sv | 148 ++++++++++++++
 tb/tb_memarbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and port-select codes.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_D  = 1'b1;

endpackage

// File: rtl/memarb_fetchbuf.sv
// One-entry fetch buffer (tag, instruction, valid) used by memarbiter when
// MEMARB_FETCH_BUF_EN is defined; lookup is combinational, state is registered.
module memarb_fetchbuf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [31:0]       fill_data,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  output logic              hit,
  output logic [31:0]       data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [31:0]       word;

  // Fill on every delivered fetch; a matching store drops the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      word  <= fill_data;
    end else if (inv_en && (inv_addr == tag)) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

  assign hit  = valid && (lookup_addr == tag);
  assign data = word;

endmodule

// File: rtl/memarbiter.sv
// Single-port memory arbiter between fetch and MEM-stage load/store (data wins).
// Optional one-entry fetch buffer enabled by defining MEMARB_FETCH_BUF_EN.
module memarbiter
  import memarb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcf,
  input  logic              ifreq,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dwdata,
  output logic [31:0]       instrf,
  output logic              ifvalid,
  output logic [31:0]       drdata,
  output logic              dvalid,
  output logic              stallf,
  output logic              stallm,
  output logic [ADDR_W-1:0] maddr,
  output logic [31:0]       mwdata,
  output logic              mwe,
  output logic              men,
  input  logic [31:0]       mrdata
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic if_elig, d_elig, sel, if_hit, if_miss, last;
  logic fb_hit;
  logic [31:0] fb_data;

  assign if_elig = ifreq && !ifvalid;
  assign d_elig  = dreq && !dvalid;
  assign sel     = d_elig ? SEL_D : SEL_IF;
  assign last    = (cnt == CNT_LAST);

`ifdef MEMARB_FETCH_BUF_EN
  logic fb_fill, fb_inv, fb_hazard;

  assign fb_fill = (state == IFETCH) && last && ifreq;
  assign fb_inv  = (state == IDLE) && d_elig && dwe;
  // A buffered word is stale if the store winning this same cycle overwrites it.
  assign fb_hazard = d_elig && dwe && (daddr == pcf);

  logic fb_lookup_hit;

  memarb_fetchbuf #(.ADDR_W(ADDR_W)) u_fetchbuf (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (pcf),
    .fill_en     (fb_fill),
    .fill_addr   (maddr),
    .fill_data   (mrdata),
    .inv_en      (fb_inv),
    .inv_addr    (daddr),
    .hit         (fb_lookup_hit),
    .data        (fb_data)
  );

  assign fb_hit = fb_lookup_hit && !fb_hazard;
`else
  assign fb_hit  = 1'b0;
  assign fb_data = 32'h0000_0000;
`endif

  assign if_hit  = (state == IDLE) && if_elig && fb_hit;
  assign if_miss = if_elig && !fb_hit;

  assign stallf = !reset && ifreq && !ifvalid;
  assign stallm = !reset && dreq && !dvalid;

  // Arbitration, wait counting and registered return of memory data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      instrf  <= 32'h0000_0000;
      drdata  <= 32'h0000_0000;
      maddr   <= '0;
      mwdata  <= 32'h0000_0000;
      men     <= 1'b0;
      mwe     <= 1'b0;
      ifvalid <= 1'b0;
      dvalid  <= 1'b0;
    end else begin
      ifvalid <= 1'b0;
      dvalid  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (if_hit) begin
            ifvalid <= 1'b1;
            instrf  <= fb_data;
          end
          if (d_elig || if_miss) begin
            state <= (sel == SEL_D) ? DACC : IFETCH;
            maddr <= (sel == SEL_D) ? daddr : pcf;
            mwe   <= (sel == SEL_D) && dwe;
            men   <= 1'b1;
            if (sel == SEL_D) begin
              mwdata <= dwdata;
            end
          end else begin
            men <= 1'b0;
            mwe <= 1'b0;
          end
        end
        IFETCH, DACC: begin
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
            men   <= 1'b0;
            mwe   <= 1'b0;
            // A dropped request still finishes on the memory but returns nothing.
            if (state == IFETCH) begin
              if (ifreq) begin
                ifvalid <= 1'b1;
                instrf  <= mrdata;
              end
            end else if (dreq) begin
              dvalid <= 1'b1;
              if (!mwe) begin
                drdata <= mrdata;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          men   <= 1'b0;
          mwe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memarbiter.sv
// Scoreboard bench for memarbiter (WAIT_CYCLES=2): stimulus queues expected
// returns with their arrival cycle; a negedge monitor pops and compares them.
module tb_memarbiter;

  logic        clk;
  logic        reset;
  logic [31:0] pcf, daddr, dwdata, mrdata;
  logic        ifreq, dreq, dwe;
  logic [31:0] instrf, drdata, maddr, mwdata;
  logic        ifvalid, dvalid, stallf, stallm, mwe, men;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   c;

  memarbiter #(.WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .pcf(pcf), .ifreq(ifreq), .dreq(dreq), .dwe(dwe),
    .daddr(daddr), .dwdata(dwdata), .instrf(instrf), .ifvalid(ifvalid),
    .drdata(drdata), .dvalid(dvalid), .stallf(stallf), .stallm(stallm),
    .maddr(maddr), .mwdata(mwdata), .mwe(mwe), .men(men), .mrdata(mrdata)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_000A;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign mrdata = men ? memf(maddr) : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ifvalid === 1'b1) begin
      if (if_q.size() == 0) chk("ifvalid_unexpected", 32'(ifvalid), 32'd0);
      else begin
        e = if_q.pop_front();
        chk("instrf", instrf, e.data);
        chk("ifvalid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (dvalid === 1'b1) begin
      if (d_q.size() == 0) chk("dvalid_unexpected", 32'(dvalid), 32'd0);
      else begin
        e = d_q.pop_front();
        chk("drdata", drdata, e.data);
        chk("dvalid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ifreq = 1'b1; dreq = 1'b1; dwe = 1'b0;
    pcf = 32'h0; daddr = 32'h0; dwdata = 32'h0;

    // Reset held three cycles with both requests high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_men", 32'(men), 32'd0);
      chk("rst_ifvalid", 32'(ifvalid), 32'd0);
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_stallf", 32'(stallf), 32'd0);
      chk("rst_stallm", 32'(stallm), 32'd0);
      chk("rst_maddr", maddr, 32'd0);
    end
    reset = 1'b0; ifreq = 1'b0; dreq = 1'b0;
    tick();

    // Plain fetch of address 0.
    pcf = 32'h0; ifreq = 1'b1; c = cyc;
    if_q.push_back('{32'h2001_000A, c + 3});
    #1 chk("f_stallf_t", 32'(stallf), 32'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("f_men", 32'(men), 32'd1);
      chk("f_maddr", maddr, 32'h0);
      chk("f_stallf", 32'(stallf), 32'd1);
    end
    tick();
    chk("f_stallf_done", 32'(stallf), 32'd0);
    ifreq = 1'b0;
    tick();

    // Fetch and load together: data first, fetch after.
    pcf = 32'h8; ifreq = 1'b1; daddr = 32'h40; dreq = 1'b1; dwe = 1'b0; c = cyc;
    d_q.push_back('{memf(32'h40), c + 3});
    if_q.push_back('{memf(32'h8), c + 6});
    tick();
    chk("b_maddr_d", maddr, 32'h40);
    chk("b_mwe", 32'(mwe), 32'd0);
    chk("b_stallf", 32'(stallf), 32'd1);
    chk("b_stallm", 32'(stallm), 32'd1);
    tick();
    tick();
    chk("b_stallm_done", 32'(stallm), 32'd0);
    dreq = 1'b0;
    tick();
    chk("b_maddr_f", maddr, 32'h8);
    chk("b_men_f", 32'(men), 32'd1);
    tick();
    tick();
    ifreq = 1'b0;
    tick();

    // Store: drdata keeps the previous load value.
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h40; dwdata = 32'hDEAD_BEEF; c = cyc;
    d_q.push_back('{memf(32'h40), c + 3});
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s_men", 32'(men), 32'd1);
      chk("s_mwe", 32'(mwe), 32'd1);
      chk("s_mwdata", mwdata, 32'hDEAD_BEEF);
    end
    tick();
    dreq = 1'b0; dwe = 1'b0;
    tick();

    // Fetch dropped in its last memory cycle.
    pcf = 32'h20; ifreq = 1'b1;
    tick();
    tick();
    ifreq = 1'b0;
    tick();
    chk("fl_men", 32'(men), 32'd0);
    chk("fl_stallf", 32'(stallf), 32'd0);
    tick();

    // Reset in the middle of a load.
    daddr = 32'h44; dreq = 1'b1; dwe = 1'b0;
    tick();
    chk("rm_men_before", 32'(men), 32'd1);
    reset = 1'b1;
    tick();
    chk("rm_men", 32'(men), 32'd0);
    chk("rm_dvalid", 32'(dvalid), 32'd0);
    chk("rm_stallm", 32'(stallm), 32'd0);
    reset = 1'b0; dreq = 1'b0;
    tick();
    chk("rm_men_after", 32'(men), 32'd0);
    tick();

`ifdef MEMARB_FETCH_BUF_EN
    // Miss fills the buffer, repeat fetch hits without touching memory.
    pcf = 32'h10; ifreq = 1'b1; c = cyc;
    if_q.push_back('{memf(32'h10), c + 3});
    repeat (3) tick();
    ifreq = 1'b0;
    tick();
    ifreq = 1'b1; c = cyc;
    if_q.push_back('{memf(32'h10), c + 1});
    tick();
    chk("fb_hit_men", 32'(men), 32'd0);
    ifreq = 1'b0;
    tick();
    // Store to the buffered address invalidates it.
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h10; dwdata = 32'h0000_1234; c = cyc;
    d_q.push_back('{32'h0, c + 3});
    repeat (3) tick();
    dreq = 1'b0; dwe = 1'b0;
    tick();
    ifreq = 1'b1; c = cyc;
    if_q.push_back('{memf(32'h10), c + 3});
    tick();
    chk("fb_inv_men", 32'(men), 32'd1);
    chk("fb_inv_maddr", maddr, 32'h10);
    tick();
    tick();
    ifreq = 1'b0;
    tick();
`endif

    repeat (3) tick();
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("d_q_empty", 32'(d_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
